// File: rtl/button_debouncer_if.sv
// Handshake bundle between the debouncer and its host: enable/raw input in,
// debounced level and qualification-busy flag out.
interface button_debouncer_if;
  logic enable_i;
  logic signal_i;
  logic level_o;
  logic busy_o;

  modport master (
    output enable_i,
    output signal_i,
    input  level_o,
    input  busy_o
  );

  modport slave (
    input  enable_i,
    input  signal_i,
    output level_o,
    output busy_o
  );
endinterface

// File: rtl/button_debouncer.sv
// Debouncer for one raw button/switch input: optional two-flop synchronizer
// (enabled by defining BUTTON_DEBOUNCER_SYNC_EN) followed by a stability-count FSM.
//
// state     | meaning
// ----------+----------------------------------------------------
// IDLE_LOW  | level_o = 0, waiting for a high sample
// WAIT_HIGH | qualifying a rising transition, counting stable highs
// IDLE_HIGH | level_o = 1, waiting for a low sample
// WAIT_LOW  | qualifying a falling transition, counting stable lows
module button_debouncer #(
  parameter int COUNT_MAX = 1000000
) (
  input  logic               clock_i,
  input  logic               reset_i,
  button_debouncer_if.slave  bus
);

  localparam int COUNT_W = $clog2(COUNT_MAX + 1);
  localparam logic [COUNT_W-1:0] CNT_LAST = COUNT_W'(COUNT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [COUNT_W-1:0] r_cnt;
  logic [COUNT_W-1:0] w_cnt_nxt;
  logic               r_level;
  logic               w_level_nxt;
  logic               r_busy;
  logic               w_busy_nxt;
  logic               w_s;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Synchronizer keeps sampling while disabled so re-enable never sees a stale value.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.signal_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = bus.signal_i;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_level_nxt = r_level;

    if (!bus.enable_i) begin
      w_state_nxt = IDLE_LOW;
      w_cnt_nxt   = '0;
      w_level_nxt = 1'b0;
    end else begin
      case (r_state)
        IDLE_LOW: begin
          w_level_nxt = 1'b0;
          if (w_s) begin
            w_state_nxt = WAIT_HIGH;
            w_cnt_nxt   = '0;
          end
        end

        // A revert on the terminal-count edge is checked first, so it wins.
        WAIT_HIGH: begin
          if (!w_s) begin
            w_state_nxt = IDLE_LOW;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = IDLE_HIGH;
            w_level_nxt = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + COUNT_W'(1);
          end
        end

        IDLE_HIGH: begin
          w_level_nxt = 1'b1;
          if (!w_s) begin
            w_state_nxt = WAIT_LOW;
            w_cnt_nxt   = '0;
          end
        end

        WAIT_LOW: begin
          if (w_s) begin
            w_state_nxt = IDLE_HIGH;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = IDLE_LOW;
            w_level_nxt = 1'b0;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + COUNT_W'(1);
          end
        end

        default: begin
          w_state_nxt = IDLE_LOW;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end
      endcase
    end

    w_busy_nxt = (w_state_nxt == WAIT_HIGH) || (w_state_nxt == WAIT_LOW);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= IDLE_LOW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.level_o = r_level;
  assign bus.busy_o  = r_busy;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: COUNT_MAX=4 and COUNT_MAX=1 instances share stimulus
// and are compared every cycle against a run-length reference model.
module tb_button_debouncer;

  localparam int CMAX = 4;
`ifdef BUTTON_DEBOUNCER_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic clock_i = 1'b0;
  logic reset_i;
  logic en;
  logic sig;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock_i = ~clock_i;

  button_debouncer_if bus4();
  button_debouncer_if bus1();

  assign bus4.enable_i = en;
  assign bus4.signal_i = sig;
  assign bus1.enable_i = en;
  assign bus1.signal_i = sig;

  button_debouncer #(.COUNT_MAX(CMAX)) dut4 (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus4.slave)
  );

  button_debouncer #(.COUNT_MAX(1)) dut1 (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus1.slave)
  );

  // Reference: level flips once the input has disagreed with it for cmax+1
  // consecutive samples since the last reset/disable; busy while such a run is open.
  int   m_run [2];
  logic m_lvl [2];
  logic m_d1, m_d2;
  int   m_cmax [2] = '{CMAX, 1};

  task automatic model_edge();
    logic s;
    s = (SYNC != 0) ? m_d2 : sig;
    for (int i = 0; i < 2; i++) begin
      if (reset_i || !en) begin
        m_lvl[i] = 1'b0;
        m_run[i] = 0;
      end else if (s != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == m_cmax[i] + 1) begin
          m_lvl[i] = s;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (reset_i) begin
      m_d1 = 1'b0;
      m_d2 = 1'b0;
    end else begin
      m_d2 = m_d1;
      m_d1 = sig;
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic s);
    reset_i = r;
    en      = e;
    sig     = s;
    @(posedge clock_i);
    model_edge();
    #1;
    check("level_cm4", int'(bus4.level_o), int'(m_lvl[0]));
    check("busy_cm4",  int'(bus4.busy_o),  int'(m_run[0] != 0));
    check("level_cm1", int'(bus1.level_o), int'(m_lvl[1]));
    check("busy_cm1",  int'(bus1.busy_o),  int'(m_run[1] != 0));
  endtask

  // Edges until the COUNT_MAX=4 instance's level reaches target, bounded.
  task automatic measure(input string tag, input logic e, input logic s,
                         input logic target, input int exp);
    int n;
    n = 0;
    do begin
      step(1'b0, e, s);
      n++;
    end while (bus4.level_o !== target && n < 100);
    check(tag, n, exp);
  endtask

  initial begin
    int run_len;
    logic val;
    m_run = '{0, 0};
    m_lvl = '{1'b0, 1'b0};
    m_d1 = 1'b0;
    m_d2 = 1'b0;

    // Reset with input held high
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    check("rst_level", int'(bus4.level_o), 0);
    check("rst_busy",  int'(bus4.busy_o),  0);
    measure("rise_latency", 1'b1, 1'b1, 1'b1, CMAX + SYNC + 1);
    measure("fall_latency", 1'b1, 1'b0, 1'b0, CMAX + SYNC + 1);

    // Bounce train then steady high
    step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1); step(1'b0, 1'b1, 1'b0);
    check("bounce_no_level", int'(bus4.level_o), 0);
    measure("bounce_latency", 1'b1, 1'b1, 1'b1, CMAX + SYNC + 1);

    // 3-cycle low glitch is rejected, 6-cycle low is accepted
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
    check("glitch_kept_high", int'(bus4.level_o), 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < SYNC + 2; i++) step(1'b0, 1'b1, 1'b0);
    check("long_low_fell", int'(bus4.level_o), 0);

    // Disable mid-qualification (cnt=2), then requalify from scratch
    for (int i = 0; i < SYNC + 3; i++) step(1'b0, 1'b1, 1'b1);
    check("pre_disable_busy", int'(bus4.busy_o), 1);
    step(1'b0, 1'b0, 1'b1);
    check("disable_busy",  int'(bus4.busy_o),  0);
    check("disable_level", int'(bus4.level_o), 0);
    measure("reenable_latency", 1'b1, 1'b1, 1'b1, CMAX + 1);

    // One-cycle reset while high
    step(1'b1, 1'b1, 1'b1);
    check("rst_pulse_level", int'(bus4.level_o), 0);
    measure("post_rst_latency", 1'b1, 1'b1, 1'b1, CMAX + SYNC + 1);

    // Randomized runs with occasional disable and reset
    for (int k = 0; k < 600; k++) begin
      run_len = $urandom_range(1, 7);
      val = 1'($urandom_range(0, 1));
      for (int j = 0; j < run_len; j++) begin
        step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 29) == 0) ? 1'b0 : 1'b1,
             val);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
